ifetch_queue: RTL and testbench

- Fetch stage directly downstream of the PC register.
- Takes the current fetch address and issues in-order requests to instruction memory.
- Buffers returned words with their PC in a small queue feeding decode.
- Throttles the PC via a stall output, and flushes on control-flow redirects (branch/jump/JALR).

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/ifetch_queue.sv | 139 +++++++++++++
 tb/tb_ifetch_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port and a synchronous clear.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; validity comes solely from the reset pointers and count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: issues in-order imem requests from the PC and queues {pc, instr} for decode.
// Optional macro IFETCH_ALIGN_CHECK_EN turns misaligned PCs into flagged NOP entries.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    output logic            pc_stall_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic            instr_misalign_o,
`endif
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   q_count;
    logic [CW:0]     inflight_sum;
    logic            q_empty, q_full, q_push, q_pop;
    fetch_entry_t    q_entry, q_head;
    logic [XLEN-1:0] tag_head;
    logic [CW-1:0]   tag_count;
    logic            tag_empty, tag_full;
    logic            credit_ok, misalign, direct_push, accept;
    logic            resp, resp_keep;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Credit uses registered occupancy only: a pop this cycle frees space next cycle.
    assign inflight_sum = {1'b0, q_count} + {1'b0, outstanding};
    assign credit_ok    = (outstanding < CW'(MAX_OUTSTANDING))
                       && (inflight_sum < (CW+1)'(DEPTH));

    assign imem_req_o  = !rst && !redirect_i && credit_ok && !misalign;
    assign imem_addr_o = word_align(pc_i);
    assign accept      = imem_req_o && imem_ready_i;
    // A misaligned entry bypasses memory, so it waits for in-flight words to keep order.
    assign direct_push = !rst && !redirect_i && credit_ok && misalign && (outstanding == '0);
    assign pc_stall_o  = !rst && !accept && !direct_push && !redirect_i;

    assign resp      = imem_rvalid_i && (outstanding != '0);
    assign resp_keep = resp && (drop == '0) && !redirect_i;
    assign q_push    = resp_keep || direct_push;
    assign q_pop     = instr_valid_o && instr_ready_i && !redirect_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        q_entry = '0;
        if (direct_push) begin
            q_entry.pc       = pc_i;
            q_entry.instr    = NOP_INSN;
            q_entry.misalign = 1'b1;
        end else begin
            q_entry.pc    = tag_head;
            q_entry.instr = imem_rdata_i;
        end
    end

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (q_push),
        .push_data (q_entry),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Tags survive a redirect so they stay paired with the responses being dropped.
    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (accept),
        .push_data (pc_i),
        .pop       (resp),
        .pop_data  (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            unique case ({accept, resp})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (redirect_i)
                drop <= resp ? outstanding - 1'b1 : outstanding;
            else if (resp && (drop != '0))
                drop <= drop - 1'b1;
        end
    end

    assign instr_valid_o = !rst && !q_empty;
    assign instr_o       = instr_valid_o ? q_head.instr : '0;
    assign instr_pc_o    = instr_valid_o ? q_head.pc    : '0;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign instr_misalign_o = instr_valid_o && q_head.misalign;
`endif

    logic unused_ok;
    assign unused_ok = ^{tag_count, tag_full, tag_empty, q_head.misalign};

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(q_push && q_full));
            assert (!(imem_rvalid_i && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: PC/memory models drive the DUT, a scoreboard checks decode output.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        redirect_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        instr_misalign_o;
`endif

    ifetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .redirect_i    (redirect_i),
        .pc_stall_o    (pc_stall_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
`ifdef IFETCH_ALIGN_CHECK_EN
        .instr_misalign_o (instr_misalign_o),
`endif
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t  exp_q[$];
    pend_t pend[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;
    int acc_cnt = 0;
    int max_pend = 0;
    logic [31:0] pc_reg = '0;
    logic mem_ready = 1'b0;
    logic dec_ready = 1'b0;

    logic t_req, t_stall, t_acc, t_pop, t_valid;
    logic [31:0] t_pc, t_instr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample before posedge, advance models after posedge.
    task automatic tick(input logic redir, input logic [31:0] target);
        exp_t  e;
        pend_t p;
        redirect_i    = redir;
        pc_i          = pc_reg;
        imem_ready_i  = mem_ready;
        instr_ready_i = dec_ready;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word_of(pend[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        #1;
        t_req   = imem_req_o;
        t_stall = pc_stall_o;
        t_valid = instr_valid_o;
        t_acc   = imem_req_o && imem_ready_i;
        t_pop   = instr_valid_o && instr_ready_i && !redir;
        t_pc    = instr_pc_o;
        t_instr = instr_o;
        if (redir) check("no_req_on_redirect", imem_req_o, 0);
        if (pc_reg[1:0] == 2'b00) check("pc_stall", pc_stall_o, !t_acc && !redir);
        if (t_acc) check("imem_addr", imem_addr_o, {pc_reg[31:2], 2'b00});
        if (t_pop) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", instr_valid_o, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr_pc", instr_pc_o, e.pc);
                check("sb_instr", instr_o, e.instr);
`ifdef IFETCH_ALIGN_CHECK_EN
                check("sb_misalign", instr_misalign_o, e.mis);
`endif
            end
        end
        @(posedge clk);
        if (imem_rvalid_i) void'(pend.pop_front());
        if (t_acc) begin
            p.addr = pc_reg;
            p.due  = cyc + lat;
            pend.push_back(p);
            acc_cnt++;
            e.pc = pc_reg; e.instr = word_of(pc_reg); e.mis = 1'b0;
            exp_q.push_back(e);
        end
        if (pend.size() > max_pend) max_pend = pend.size();
        if (redir) begin
            exp_q.delete();
            pc_reg = target;
        end else if (t_acc) begin
            pc_reg = pc_reg + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        redirect_i    = 1'b0;
        imem_ready_i  = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        pc_i          = '0;
        #1;
        check("rst_req", imem_req_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_stall", pc_stall_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_instr_pc", instr_pc_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        exp_q.delete();
        #1;
        check("post_rst_empty", instr_valid_o, 0);
    endtask

    task automatic drain();
        mem_ready = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (pend.size() == 0 && exp_q.size() == 0) break;
            tick(1'b0, '0);
        end
        check("drain_done", pend.size() + exp_q.size(), 0);
    endtask

    task automatic wait_first_pop(input string tag, input logic [31:0] exp_pc);
        t_pop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, '0);
            if (t_pop) break;
        end
        check({tag, "_seen"}, t_pop, 1);
        check({tag, "_pc"}, t_pc, exp_pc);
    endtask

    initial begin
        int first_acc, first_pop, npop;
        logic [31:0] pops [3];

        @(negedge clk);
        do_reset();

        // 1-cycle memory, decode always ready: steady one instruction per cycle.
        pc_reg = 32'h0; lat = 1; mem_ready = 1'b1; dec_ready = 1'b1;
        first_acc = -1; first_pop = -1; npop = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, '0);
            if (t_acc && first_acc < 0) first_acc = cyc - 1;
            if (t_pop) begin
                if (first_pop < 0) first_pop = cyc - 1;
                if (npop < 3) pops[npop] = t_pc;
                npop++;
            end
            if (i >= 2) check("t1_stream_valid", t_pop, 1);
            if (i >= 1) check("t1_no_stall", t_stall, 0);
        end
        check("t1_latency", first_pop - first_acc, 2);
        check("t1_pc0", pops[0], 32'h0);
        check("t1_pc1", pops[1], 32'h4);
        check("t1_pc2", pops[2], 32'h8);

        // Reset in the middle of traffic.
        do_reset();

        // Decode blocked: exactly DEPTH accepts, then throttle; release drains one per cycle.
        pc_reg = 32'h0; lat = 1; mem_ready = 1'b1; dec_ready = 1'b0; acc_cnt = 0;
        repeat (10) tick(1'b0, '0);
        check("t2_accepts", acc_cnt, 4);
        check("t2_req_low", t_req, 0);
        check("t2_stall_high", t_stall, 1);
        check("t2_valid", t_valid, 1);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0);
            check("t2_pop_per_cycle", t_pop, 1);
        end
        check("t2_issue_resumed", acc_cnt > 4, 1);
        drain();

        // 3-cycle memory: outstanding capped at 2, tags stay paired.
        pc_reg = 32'h10; lat = 3; mem_ready = 1'b1; dec_ready = 1'b1; max_pend = 0;
        first_pop = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, '0);
            if (t_pop && first_pop < 0) begin
                first_pop = cyc;
                check("t3_first_pc", t_pc, 32'h10);
                check("t3_first_word", t_instr, word_of(32'h10));
            end
        end
        check("t3_max_outstanding", max_pend, 2);
        check("t3_popped", first_pop >= 0, 1);
        drain();

        // Redirect with 0x20/0x24 outstanding and a queued word: all discarded.
        pc_reg = 32'h1C; lat = 1; mem_ready = 1'b1; dec_ready = 1'b0;
        tick(1'b0, '0);
        mem_ready = 1'b0;
        tick(1'b0, '0);
        lat = 4; mem_ready = 1'b1;
        tick(1'b0, '0);
        tick(1'b0, '0);
        check("t4_two_outstanding", pend.size(), 2);
        check("t4_queued_before", t_valid, 1);
        tick(1'b1, 32'h80);
        check("t4_flushed", instr_valid_o, 0);
        dec_ready = 1'b1;
        wait_first_pop("t4_first", 32'h80);
        drain();

        // Redirect coinciding with a response and a would-be accept.
        for (int k = 1; k <= 2; k++) begin
            pc_reg = (k == 1) ? 32'h40 : 32'h50;
            lat = k; mem_ready = 1'b1; dec_ready = 1'b1;
            repeat (k) tick(1'b0, '0);
            check("t5_rvalid_in_redirect", imem_rvalid_i, 0);
            tick(1'b1, (k == 1) ? 32'hC0 : 32'hE0);
            check("t5_no_accept", t_req, 0);
            wait_first_pop("t5_first", (k == 1) ? 32'hC0 : 32'hE0);
            drain();
        end

`ifdef IFETCH_ALIGN_CHECK_EN
        begin
            exp_t e;
            pc_reg = 32'h102; mem_ready = 1'b1; dec_ready = 1'b0;
            e.pc = 32'h102; e.instr = 32'h0000_0013; e.mis = 1'b1;
            exp_q.push_back(e);
            tick(1'b0, '0);
            check("ta_no_req", t_req, 0);
            check("ta_pc_advances", t_stall, 0);
            pc_reg = 32'h104; mem_ready = 1'b0; dec_ready = 1'b1;
            tick(1'b0, '0);
            check("ta_entry_popped", t_pop, 1);
            drain();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
